vga_scan_ctrl: RTL and testbench

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

---
 rtl/vga_scan_ctrl.sv | 97 +++++++++
 tb/tb_vga_scan_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// VGA raster scan: free-running h/v counters drive the renderer address; colour and syncs are
// registered one clock behind the address. No back-pressure: vga_data is sampled every clock.
module vga_scan_ctrl #(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 56,
    parameter int H_SYNC = 120,
    parameter int H_BP   = 64,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 37,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 23
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] vga_haddr,
    output logic [10:0] vga_vaddr,
    input  logic [11:0] vga_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_C  = 11'(V_VIS);
    localparam logic [10:0] V_VIS_M1 = 11'(V_VIS - 1);
    localparam logic [10:0] H_SS     = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_SE     = 11'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_SS     = 11'(V_VIS + V_FP);
    localparam logic [10:0] V_SE     = 11'(V_VIS + V_FP + V_SYNC - 1);

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_frame_start;
    logic [15:0] r_frame_cnt;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_active;
    logic w_hs_win;
    logic w_vs_win;
    logic w_frame_edge;

    assign w_h_wrap     = (r_h_cnt == H_LAST);
    assign w_v_wrap     = (r_v_cnt == V_LAST);
    assign w_active     = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
    assign w_hs_win     = (r_h_cnt >= H_SS) && (r_h_cnt <= H_SE);
    assign w_vs_win     = (r_v_cnt >= V_SS) && (r_v_cnt <= V_SE);
    // Last pixel of the last visible line: the next edge enters vblank.
    assign w_frame_edge = w_h_wrap && (r_v_cnt == V_VIS_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_rgb         <= '0;
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_h_cnt <= w_h_wrap ? 11'd0 : r_h_cnt + 11'd1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? 11'd0 : r_v_cnt + 11'd1;
            end
            r_rgb         <= w_active ? vga_data : 12'h000;
            r_hs          <= w_hs_win;
            r_vs          <= w_vs_win;
            r_frame_start <= w_frame_edge;
            if (w_frame_edge) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign vga_haddr   = r_h_cnt;
    assign vga_vaddr   = r_v_cnt;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vblank      = (r_v_cnt >= V_VIS_C);
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl using a reduced raster so whole frames fit in a short run.
module tb_vga_scan_ctrl;
    localparam int HV = 16, HF = 3, HS = 4, HB = 5;
    localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int LIMIT = 3000;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] fcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] vga_haddr, vga_vaddr;
    logic [11:0] vga_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vblank, frame_start;
    logic [15:0] frame_cnt;

    logic        mode;
    logic [11:0] cdata;
    logic        sb_en;
    int          preload_req, preload_ack;
    int          n_chk, n_pass;
    int          m_h, m_v;
    logic [15:0] m_f;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    assign vga_data = mode ? {1'b0, vga_haddr} : cdata;

    vga_scan_ctrl #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_haddr(vga_haddr), .vga_vaddr(vga_vaddr), .vga_data(vga_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vblank(vblank),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            if (vga_haddr == 11'(h) && vga_vaddr == 11'(v)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            tick();
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Scoreboard: at each falling edge pop the prediction for the last rising edge,
    // then predict the next rising edge from the reference raster model.
    task automatic run_scoreboard();
        exp_t e, p;
        logic [11:0] d;
        forever begin
            @(negedge clk);
            if (!sb_en) begin
                m_h = 0; m_v = 0; m_f = '0;
                sb_q.delete();
            end else begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    n_chk++;
                    if ({vga_r, vga_g, vga_b} !== e.rgb)
                        $display("FAIL sb_rgb t=%0t got %h exp %h", $time, {vga_r, vga_g, vga_b}, e.rgb);
                    else n_pass++;
                    n_chk++;
                    if (vga_hs !== e.hs) $display("FAIL sb_hs t=%0t got %b exp %b", $time, vga_hs, e.hs);
                    else n_pass++;
                    n_chk++;
                    if (vga_vs !== e.vs) $display("FAIL sb_vs t=%0t got %b exp %b", $time, vga_vs, e.vs);
                    else n_pass++;
                    n_chk++;
                    if (frame_start !== e.fs)
                        $display("FAIL sb_frame_start t=%0t got %b exp %b", $time, frame_start, e.fs);
                    else n_pass++;
                    n_chk++;
                    if (frame_cnt !== e.fcnt)
                        $display("FAIL sb_frame_cnt t=%0t got %h exp %h", $time, frame_cnt, e.fcnt);
                    else n_pass++;
                end
                n_chk++;
                if (vga_haddr !== 11'(m_h) || vga_vaddr !== 11'(m_v))
                    $display("FAIL sb_addr t=%0t got %0d,%0d exp %0d,%0d", $time, vga_haddr, vga_vaddr, m_h, m_v);
                else n_pass++;
                n_chk++;
                if (vblank !== (m_v >= VV)) $display("FAIL sb_vblank t=%0t got %b exp %b", $time, vblank, m_v >= VV);
                else n_pass++;
                if (preload_ack != preload_req) begin
                    force dut.r_frame_cnt = 16'hFFFF;
                    release dut.r_frame_cnt;
                    m_f = 16'hFFFF;
                    preload_ack = preload_req;
                end
                if (rst) begin
                    p = '0;
                    m_h = 0; m_v = 0; m_f = '0;
                end else begin
                    d = mode ? {1'b0, 11'(m_h)} : cdata;
                    p.rgb = (m_h < HV && m_v < VV) ? d : 12'h000;
                    p.hs  = (m_h >= HV + HF) && (m_h < HV + HF + HS);
                    p.vs  = (m_v >= VV + VF) && (m_v < VV + VF + VS);
                    p.fs  = (m_h == HT - 1) && (m_v == VV - 1);
                    if (p.fs) m_f = m_f + 16'd1;
                    p.fcnt = m_f;
                    if (m_h == HT - 1) begin
                        m_h = 0;
                        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                    end else begin
                        m_h = m_h + 1;
                    end
                end
                sb_q.push_back(p);
            end
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_chk++;
        if (vga_haddr !== 11'd0 || vga_vaddr !== 11'd0)
            $display("FAIL reset_addr got %0d,%0d exp 0,0", vga_haddr, vga_vaddr);
        else n_pass++;
        n_chk++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start} !== 15'd0 || frame_cnt !== 16'd0)
            $display("FAIL reset_outputs got rgb=%h hs=%b vs=%b fs=%b fc=%h exp all 0",
                     {vga_r, vga_g, vga_b}, vga_hs, vga_vs, frame_start, frame_cnt);
        else n_pass++;
    endtask

    task automatic test_const_color();
        bit ok;
        int run, maxrun, tot, hs_cnt;
        rst = 1'b0;
        tick();
        n_chk++;
        if ({vga_r, vga_g, vga_b} !== 12'hABC) $display("FAIL first_pixel got %h exp abc", {vga_r, vga_g, vga_b});
        else n_pass++;
        wait_addr(0, 1, ok);
        n_chk++;
        if (!ok) $display("FAIL const_wait got timeout exp line 1");
        else n_pass++;
        run = 0; maxrun = 0; tot = 0; hs_cnt = 0;
        for (int i = 0; i < HT; i++) begin
            tick();
            if (vga_hs) hs_cnt++;
            if ({vga_r, vga_g, vga_b} != 12'h000) begin
                run++; tot++;
            end else begin
                if (run > maxrun) maxrun = run;
                run = 0;
            end
        end
        if (run > maxrun) maxrun = run;
        n_chk++;
        if (tot != HV || maxrun != HV) $display("FAIL line_visible got tot=%0d run=%0d exp %0d", tot, maxrun, HV);
        else n_pass++;
        n_chk++;
        if (hs_cnt != HS) $display("FAIL line_hs got %0d exp %0d", hs_cnt, HS);
        else n_pass++;
    endtask

    task automatic test_frame();
        bit ok;
        int per, vs_cnt, hs_cnt;
        logic [15:0] fc0;
        wait_fs(ok);
        fc0 = frame_cnt;
        per = 0; vs_cnt = 0; hs_cnt = 0;
        for (int i = 0; i < LIMIT; i++) begin
            tick();
            per++;
            if (vga_vs) vs_cnt++;
            if (vga_hs) hs_cnt++;
            if (frame_start) break;
        end
        n_chk++;
        if (!ok || per != HT * VT) $display("FAIL frame_period got %0d exp %0d", per, HT * VT);
        else n_pass++;
        n_chk++;
        if (vs_cnt != VS * HT) $display("FAIL frame_vs got %0d exp %0d", vs_cnt, VS * HT);
        else n_pass++;
        n_chk++;
        if (hs_cnt != HS * VT) $display("FAIL frame_hs got %0d exp %0d", hs_cnt, HS * VT);
        else n_pass++;
        n_chk++;
        if (frame_cnt !== fc0 + 16'd1) $display("FAIL frame_cnt_inc got %h exp %h", frame_cnt, fc0 + 16'd1);
        else n_pass++;
    endtask

    task automatic test_wrap_boundary();
        bit ok;
        logic [15:0] fc0;
        wait_addr(HT - 1, VT - 1, ok);
        fc0 = frame_cnt;
        tick();
        n_chk++;
        if (!ok || vga_haddr !== 11'd0 || vga_vaddr !== 11'd0)
            $display("FAIL wrap_addr got %0d,%0d exp 0,0", vga_haddr, vga_vaddr);
        else n_pass++;
        n_chk++;
        if (vga_vs !== 1'b0 || frame_cnt !== fc0)
            $display("FAIL wrap_vs_fc got vs=%b fc=%h exp vs=0 fc=%h", vga_vs, frame_cnt, fc0);
        else n_pass++;
    endtask

    task automatic test_addr_data();
        bit ok;
        int h, v, bad;
        logic [11:0] exp_rgb;
        mode = 1'b1;
        wait_addr(0, 2, ok);
        bad = 0;
        for (int i = 0; i < HT; i++) begin
            h = int'(vga_haddr); v = int'(vga_vaddr);
            tick();
            exp_rgb = (h < HV && v < VV) ? 12'(h) : 12'h000;
            if ({vga_r, vga_g, vga_b} !== exp_rgb) bad++;
        end
        n_chk++;
        if (!ok || bad != 0) $display("FAIL addr_data_line got %0d bad pixels exp 0", bad);
        else n_pass++;
        wait_addr(0, VV, ok);
        bad = 0;
        for (int i = 0; i < HT; i++) begin
            tick();
            if ({vga_r, vga_g, vga_b} !== 12'h000) bad++;
        end
        n_chk++;
        if (!ok || bad != 0) $display("FAIL vblank_dark got %0d lit pixels exp 0", bad);
        else n_pass++;
    endtask

    task automatic test_frame_cnt_wrap();
        bit ok;
        int pulses;
        wait_addr(0, VV - 1, ok);
        preload_req++;
        for (int i = 0; i < 4 && preload_ack != preload_req; i++) tick();
        tick();
        n_chk++;
        if (frame_cnt !== 16'hFFFF) $display("FAIL preload got %h exp ffff", frame_cnt);
        else n_pass++;
        wait_fs(ok);
        n_chk++;
        if (!ok || frame_cnt !== 16'h0000) $display("FAIL fc_wrap got %h exp 0000", frame_cnt);
        else n_pass++;
        pulses = 1;
        for (int i = 0; i < HT; i++) begin
            tick();
            if (frame_start) pulses++;
        end
        n_chk++;
        if (pulses != 1 || frame_cnt !== 16'h0000)
            $display("FAIL fc_wrap_pulse got pulses=%0d fc=%h exp 1, 0000", pulses, frame_cnt);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        bit ok;
        wait_addr(HV / 2, VV / 2, ok);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start} !== 15'd0 || frame_cnt !== 16'd0 ||
                vga_haddr !== 11'd0 || vga_vaddr !== 11'd0)
                $display("FAIL midrst_%0d got rgb=%h fs=%b fc=%h addr=%0d,%0d exp all 0",
                         i, {vga_r, vga_g, vga_b}, frame_start, frame_cnt, vga_haddr, vga_vaddr);
            else n_pass++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (vga_haddr !== 11'(i) || vga_vaddr !== 11'd0)
                $display("FAIL restart_%0d got %0d,%0d exp %0d,0", i, vga_haddr, vga_vaddr, i);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; cdata = 12'hABC; sb_en = 1'b0;
        preload_req = 0; preload_ack = 0; n_chk = 0; n_pass = 0;
        fork
            run_scoreboard();
        join_none
        repeat (3) tick();
        sb_en = 1'b1;
        test_reset();
        test_const_color();
        test_frame();
        test_wrap_boundary();
        test_addr_data();
        test_frame_cnt_wrap();
        test_mid_reset();
        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
